// File: rtl/uart_tx_core.sv
// UART transmitter core with bit-serial CRC-8 generator.
// Frame: start, 8 data bits LSB first, odd parity or CRC-8 (LSB first), stop.
// CRC-8 polynomial x^8+x^2+x+1 (0x07), init 0x00, data fed MSB first.
// Optional feature: define UART_TX_HOLD_BUF_EN for a 1-entry hold buffer that
// allows back-to-back frames without an idle gap.

module uart_crc_gen (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       init_i,
  input  logic       en_i,
  input  logic       bit_i,
  output logic [7:0] crc_o,
  output logic [7:0] crc_nxt_o
);

  localparam logic [7:0] POLY = 8'h07;

  logic [7:0] crc_q;
  logic       fb;

  // Next CRC value if the current input bit were shifted in.
  always_comb begin
    fb        = crc_q[7] ^ bit_i;
    crc_nxt_o = {crc_q[6:0], 1'b0} ^ (fb ? POLY : 8'h00);
  end

  // CRC register: cleared at frame start, advanced once per data bit.
  always_ff @(posedge clk_i) begin
    if (rst_i || init_i) begin
      crc_q <= 8'h00;
    end else if (en_i) begin
      crc_q <= crc_nxt_o;
    end
  end

  assign crc_o = crc_q;

endmodule

module uart_tx_core #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [7:0] tx_data_i,
  input  logic       tx_valid_i,
  output logic       tx_ready_o,
  input  logic       crc_en_i,
  output logic       tx_o,
  output logic       busy_o,
  output logic       tx_int_o
);

  localparam logic [15:0] BAUD_MAX = 16'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_CRC,
    S_STOP
  } state_t;

  state_t      state_q, state_d;
  logic [15:0] baud_q, baud_d;
  logic [2:0]  bit_q, bit_d;
  logic [7:0]  shift_q, shift_d;
  logic [7:0]  data_q, data_d;
  logic        mode_q, mode_d;
  logic        tx_q, tx_d;
  logic        int_q, int_d;

  logic        tick;
  logic        accept;
  logic        start_direct;
  logic        launch;
  logic [7:0]  launch_byte;
  logic        launch_mode;
  logic [2:0]  bit_inc;

  logic        crc_init;
  logic        crc_en;
  logic        crc_bit;
  logic [7:0]  crc;
  logic [7:0]  crc_nxt;

`ifdef UART_TX_HOLD_BUF_EN
  logic        hold_valid_q, hold_valid_d;
  logic [7:0]  hold_data_q, hold_data_d;
  logic        hold_mode_q, hold_mode_d;
  logic        load_hold;
  logic        drain;
`endif

  uart_crc_gen u_crc (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .init_i    (crc_init),
    .en_i      (crc_en),
    .bit_i     (crc_bit),
    .crc_o     (crc),
    .crc_nxt_o (crc_nxt)
  );

  assign tick    = (baud_q == BAUD_MAX);
  assign bit_inc = bit_q + 3'd1;

  // Handshake: base build accepts only in IDLE; hold build also while the buffer is empty.
`ifdef UART_TX_HOLD_BUF_EN
  assign tx_ready_o   = (state_q == S_IDLE) || !hold_valid_q;
  assign accept       = tx_valid_i && tx_ready_o;
  assign start_direct = accept && (state_q == S_IDLE) && !hold_valid_q;
  assign load_hold    = accept && !start_direct;
`else
  assign tx_ready_o   = (state_q == S_IDLE);
  assign accept       = tx_valid_i && tx_ready_o;
  assign start_direct = accept;
`endif

  // Next-state, baud/bit counters, serial output and CRC control.
  // NOTE: every signal gets a default first so no path leaves it unassigned (no latches).
  always_comb begin
    state_d     = state_q;
    baud_d      = baud_q;
    bit_d       = bit_q;
    shift_d     = shift_q;
    data_d      = data_q;
    mode_d      = mode_q;
    tx_d        = tx_q;
    int_d       = 1'b0;
    launch      = 1'b0;
    launch_byte = tx_data_i;
    launch_mode = crc_en_i;
    crc_init    = 1'b0;
    crc_en      = 1'b0;
    crc_bit     = 1'b0;
`ifdef UART_TX_HOLD_BUF_EN
    hold_valid_d = hold_valid_q;
    hold_data_d  = hold_data_q;
    hold_mode_d  = hold_mode_q;
    drain        = 1'b0;
`endif

    if (state_q != S_IDLE) begin
      baud_d = tick ? 16'd0 : baud_q + 16'd1;
    end

    case (state_q)
      S_IDLE: begin
        tx_d = 1'b1;
        if (start_direct) begin
          launch = 1'b1;
        end
      end
      S_START: begin
        if (tick) begin
          state_d = S_DATA;
          bit_d   = 3'd0;
          tx_d    = shift_q[0];
        end
      end
      S_DATA: begin
        if (tick) begin
          // CRC is computed over the byte MSB first, matching the receiver.
          crc_en  = 1'b1;
          crc_bit = data_q[3'd7 - bit_q];
          if (bit_q == 3'd7) begin
            bit_d = 3'd0;
            if (mode_q) begin
              state_d = S_CRC;
              // The CRC register updates on this same edge, so take bit 0 of its next value.
              tx_d    = crc_nxt[0];
            end else begin
              state_d = S_PARITY;
              tx_d    = ~^data_q;
            end
          end else begin
            bit_d   = bit_inc;
            shift_d = {1'b0, shift_q[7:1]};
            tx_d    = shift_q[1];
          end
        end
      end
      S_PARITY: begin
        if (tick) begin
          state_d = S_STOP;
          bit_d   = 3'd0;
          tx_d    = 1'b1;
        end
      end
      S_CRC: begin
        if (tick) begin
          if (bit_q == 3'd7) begin
            state_d = S_STOP;
            bit_d   = 3'd0;
            tx_d    = 1'b1;
          end else begin
            bit_d = bit_inc;
            tx_d  = crc[bit_inc];
          end
        end
      end
      S_STOP: begin
        if (tick) begin
          int_d = 1'b1;
          bit_d = 3'd0;
`ifdef UART_TX_HOLD_BUF_EN
          if (hold_valid_q) begin
            drain       = 1'b1;
            launch      = 1'b1;
            launch_byte = hold_data_q;
            launch_mode = hold_mode_q;
          end else begin
            state_d = S_IDLE;
            tx_d    = 1'b1;
          end
`else
          state_d = S_IDLE;
          tx_d    = 1'b1;
`endif
        end
      end
      default: begin
        state_d = S_IDLE;
        tx_d    = 1'b1;
      end
    endcase

    // Frame launch: load the byte, drive the start bit and restart the CRC.
    if (launch) begin
      state_d  = S_START;
      baud_d   = 16'd0;
      bit_d    = 3'd0;
      shift_d  = launch_byte;
      data_d   = launch_byte;
      mode_d   = launch_mode;
      tx_d     = 1'b0;
      crc_init = 1'b1;
    end

`ifdef UART_TX_HOLD_BUF_EN
    // A byte arriving in the same cycle as a drain takes the freed slot.
    if (drain) begin
      hold_valid_d = 1'b0;
    end
    if (load_hold) begin
      hold_valid_d = 1'b1;
      hold_data_d  = tx_data_i;
      hold_mode_d  = crc_en_i;
    end
`endif
  end

  // State and datapath registers with synchronous reset.
  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      // NOTE: the data registers are cleared too, so a restarted link never replays stale bytes.
      state_q <= S_IDLE;
      baud_q  <= 16'd0;
      bit_q   <= 3'd0;
      shift_q <= 8'h00;
      data_q  <= 8'h00;
      mode_q  <= 1'b0;
      tx_q    <= 1'b1;
      int_q   <= 1'b0;
`ifdef UART_TX_HOLD_BUF_EN
      hold_valid_q <= 1'b0;
      hold_data_q  <= 8'h00;
      hold_mode_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      data_q  <= data_d;
      mode_q  <= mode_d;
      tx_q    <= tx_d;
      int_q   <= int_d;
`ifdef UART_TX_HOLD_BUF_EN
      hold_valid_q <= hold_valid_d;
      hold_data_q  <= hold_data_d;
      hold_mode_q  <= hold_mode_d;
`endif
    end
  end

  assign tx_o     = tx_q;
  assign busy_o   = (state_q != S_IDLE);
  assign tx_int_o = int_q;

endmodule

// File: tb/tb_uart_tx_core.sv
// Self-checking bench for uart_tx_core with CLKS_PER_BIT = 4.
// Expected frames are hand-built {stop, parity/CRC, data, start} vectors,
// bit k of the vector being the k-th bit on the wire.

module tb_uart_tx_core;

  localparam int N = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic       crc_en;
  logic       tx;
  logic       busy;
  logic       tx_int;

  int n_checks = 0;
  int n_fail   = 0;

  uart_tx_core #(.CLKS_PER_BIT(N)) dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .tx_data_i  (tx_data),
    .tx_valid_i (tx_valid),
    .tx_ready_o (tx_ready),
    .crc_en_i   (crc_en),
    .tx_o       (tx),
    .busy_o     (busy),
    .tx_int_o   (tx_int)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Send one byte and follow the whole frame cycle by cycle.
  // Cycle c is the interval between accept-edge+c and accept-edge+c+1.
  task automatic run_frame(input string tag, input logic [7:0] b, input logic m,
                           input logic [17:0] exp_bits, input int nbits,
                           output logic [17:0] got_bits);
    int bad;
    int int_cnt;
    int int_at;
    logic exp_tx;
    bad      = 0;
    int_cnt  = 0;
    int_at   = -1;
    got_bits = '1;
    @(negedge clk);
    tx_data  = b;
    crc_en   = m;
    tx_valid = 1'b1;
    check({tag, " ready before accept"}, 32'(tx_ready), 32'd1);
    @(posedge clk);
    #1 tx_valid = 1'b0;
    for (int c = 0; c < nbits * N + 3; c++) begin
      @(negedge clk);
      exp_tx = (c < nbits * N) ? exp_bits[c / N] : 1'b1;
      if (tx !== exp_tx) bad++;
      if ((c % N) == N / 2 && c < nbits * N) got_bits[c / N] = tx;
      if (tx_int === 1'b1) begin
        int_cnt++;
        int_at = c;
      end
      if (c == 0) begin
        check({tag, " busy after accept"}, 32'(busy), 32'd1);
        check({tag, " ready during frame"}, 32'(tx_ready), 32'd0);
      end
      if (c == nbits * N - 1) check({tag, " busy last stop clock"}, 32'(busy), 32'd1);
      if (c == nbits * N) begin
        check({tag, " busy after frame"}, 32'(busy), 32'd0);
        check({tag, " ready after frame"}, 32'(tx_ready), 32'd1);
      end
    end
    check({tag, " wire bits"}, 32'(got_bits & ((18'd1 << nbits) - 18'd1)),
          32'(exp_bits & ((18'd1 << nbits) - 18'd1)));
    check({tag, " bad tx cycles"}, 32'(bad), 32'd0);
    check({tag, " tx_int count"}, 32'(int_cnt), 32'd1);
    check({tag, " tx_int position"}, 32'(int_at), 32'(nbits * N));
  endtask

  initial begin
    logic [17:0] got;
    int bad_tx, bad_rdy, bad_busy, bad_int;
    int acc2, start2, int_cnt, int1, int2;
    int exp_acc2, exp_start2;
    logic drop;
    logic [10:0] f55, faa;

    rst      = 1'b1;
    tx_data  = 8'h00;
    tx_valid = 1'b0;
    crc_en   = 1'b0;

    // Reset values while reset is held.
    repeat (3) @(negedge clk);
    check("reset tx_o", 32'(tx), 32'd1);
    check("reset ready", 32'(tx_ready), 32'd1);
    check("reset busy", 32'(busy), 32'd0);
    check("reset tx_int", 32'(tx_int), 32'd0);
    rst = 1'b0;

    // Idle for 20 clocks: outputs must stay at their idle values.
    bad_tx = 0; bad_rdy = 0; bad_busy = 0; bad_int = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (tx !== 1'b1) bad_tx++;
      if (tx_ready !== 1'b1) bad_rdy++;
      if (busy !== 1'b0) bad_busy++;
      if (tx_int !== 1'b0) bad_int++;
    end
    check("idle tx_o", 32'(bad_tx), 32'd0);
    check("idle ready", 32'(bad_rdy), 32'd0);
    check("idle busy", 32'(bad_busy), 32'd0);
    check("idle tx_int", 32'(bad_int), 32'd0);

    // 0xA5 parity frame: 0,1,0,1,0,0,1,0,1,P=1,1.
    run_frame("a5 parity", 8'hA5, 1'b0, 18'b1_1_10100101_0, 11, got);

    // 0x07 parity frame: three ones, so the odd parity bit is 0.
    run_frame("07 parity", 8'h07, 1'b0, 18'b1_0_00000111_0, 11, got);
    check("07 decoded byte", 32'(got[8:1]), 32'h07);
    check("07 parity bit", 32'(got[9]), 32'd0);

    // 0x3C CRC frame: CRC-8(0x07) of 0x3C is 0xB4, sent LSB first.
    run_frame("3c crc", 8'h3C, 1'b1, 18'b1_10110100_00111100_0, 18, got);
    check("3c decoded byte", 32'(got[8:1]), 32'h3C);
    check("3c crc field", 32'(got[16:9]), 32'hB4);

    // Reset in the middle of DATA while the line is low.
    @(negedge clk);
    tx_data  = 8'h00;
    crc_en   = 1'b0;
    tx_valid = 1'b1;
    @(posedge clk);
    #1 tx_valid = 1'b0;
    repeat (13) @(negedge clk);
    check("mid-frame tx low", 32'(tx), 32'd0);
    rst = 1'b1;
    @(negedge clk);
    check("abort tx_o", 32'(tx), 32'd1);
    check("abort busy", 32'(busy), 32'd0);
    check("abort ready", 32'(tx_ready), 32'd1);
    rst = 1'b0;
    bad_tx = 0; bad_int = 0;
    for (int i = 0; i < 12 * N; i++) begin
      @(negedge clk);
      if (tx !== 1'b1) bad_tx++;
      if (tx_int !== 1'b0) bad_int++;
    end
    check("abort line idle", 32'(bad_tx), 32'd0);
    check("abort no tx_int", 32'(bad_int), 32'd0);
    run_frame("a5 after abort", 8'hA5, 1'b0, 18'b1_1_10100101_0, 11, got);

    // Back-to-back: 0x55 then 0xAA presented immediately and held until accepted.
`ifdef UART_TX_HOLD_BUF_EN
    exp_acc2   = 1;
    exp_start2 = 11 * N;
`else
    exp_acc2   = 11 * N + 1;
    exp_start2 = 11 * N + 1;
`endif
    f55 = 11'b1_1_01010101_0;
    faa = 11'b1_1_10101010_0;
    acc2 = -1; start2 = -1; int_cnt = 0; int1 = -1; int2 = -1;
    drop = 1'b0; bad_tx = 0;
    @(negedge clk);
    tx_data  = 8'h55;
    crc_en   = 1'b0;
    tx_valid = 1'b1;
    @(posedge clk);
    #1 tx_data = 8'hAA;
    for (int c = 0; c < 22 * N + 8; c++) begin
      @(negedge clk);
      if (drop) begin
        tx_valid = 1'b0;
        drop     = 1'b0;
      end
      if (tx_valid && tx_ready === 1'b1) begin
        acc2 = c + 1;
        drop = 1'b1;
      end
      if (c < 11 * N && (c % N) == N / 2 && tx !== f55[c / N]) bad_tx++;
      if (start2 < 0 && c >= 10 * N && tx === 1'b0) start2 = c;
      if (start2 >= 0 && c >= start2 && c < start2 + 11 * N &&
          ((c - start2) % N) == N / 2 && tx !== faa[(c - start2) / N]) bad_tx++;
      if (tx_int === 1'b1) begin
        int_cnt++;
        if (int1 < 0) int1 = c;
        else int2 = c;
      end
    end
    tx_valid = 1'b0;
    check("b2b second accept", 32'(acc2), 32'(exp_acc2));
    check("b2b second start", 32'(start2), 32'(exp_start2));
    check("b2b frame bits", 32'(bad_tx), 32'd0);
    check("b2b tx_int count", 32'(int_cnt), 32'd2);
    check("b2b first tx_int", 32'(int1), 32'(11 * N));
    check("b2b second tx_int", 32'(int2), 32'(exp_start2 + 11 * N));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
